// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch stage between the instruction ROM
// and the if_id register. Issues sequential word fetches over a
// req/gnt/rvalid bus and buffers {addr, ins} pairs in a DEPTH-entry FIFO.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   mem_req/mem_addr  fetch request and word-aligned fetch address
//   mem_gnt           request accepted when mem_req & mem_gnt
//   mem_rvalid/rdata  in-order responses, >=1 cycle after grant
//   flush/flush_pc    redirect; drops buffered and in-flight fetches
//   ins_valid/ready   FIFO head handshake toward if_id
//   ins/ins_addr      head instruction and address (0 when not valid)
`timescale 1ns/1ps
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_addr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_resp_pc;
    ptr_t        r_wptr;
    ptr_t        r_rptr;
    cnt_t        r_count;
    cnt_t        r_outst;
    cnt_t        r_discard;
    logic [31:0] r_buf_addr [DEPTH];
    logic [31:0] r_buf_ins  [DEPTH];

    logic [CW:0] w_used;
    logic        w_credit;
    logic        w_gnt;
    logic        w_rsp;
    logic        w_drop;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_flush_pc;

    // Every granted request owns a FIFO slot until it is popped, so the
    // FIFO can never overflow. No credit is taken for a same-cycle pop.
    assign w_used   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_credit = w_used < DEPTH_C;

    // Gated by rst so the bus is quiet the instant reset asserts.
    assign mem_req  = rst & ~flush & w_credit;
    assign mem_addr = r_fetch_pc;

    assign w_gnt      = mem_req & mem_gnt;
    // A response with nothing outstanding is a stray and is ignored.
    assign w_rsp      = mem_rvalid & (r_outst != '0);
    assign w_drop     = r_discard != '0;
    assign w_push     = w_rsp & ~w_drop & ~flush;
    assign ins_valid  = r_count != '0;
    assign w_pop      = ins_valid & ins_ready & ~flush;
    assign w_flush_pc = flush_pc & 32'hFFFF_FFFC;

    assign ins      = ins_valid ? r_buf_ins[r_rptr]  : '0;
    assign ins_addr = ins_valid ? r_buf_addr[r_rptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
        end else if (flush) begin
            r_fetch_pc <= w_flush_pc;
            r_resp_pc  <= w_flush_pc;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            // mem_req is low during flush, so no grant here. A response
            // landing now is dropped directly; the rest are discarded.
            r_outst    <= r_outst - cnt_t'(w_rsp);
            r_discard  <= r_outst - cnt_t'(w_rsp);
        end else begin
            if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outst <= r_outst + cnt_t'(w_gnt) - cnt_t'(w_rsp);
            if (w_rsp && w_drop) begin
                r_discard <= r_discard - cnt_t'(1);
            end
            if (w_push) begin
                r_wptr    <= r_wptr + ptr_t'(1);
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
        end
    end

    // Storage needs no reset: outputs are masked by ins_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_wptr] <= r_resp_pc;
            r_buf_ins[r_wptr]  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: scoreboard bench for if_prefetch.
// Directed phases push expected {addr, ins}; a monitor checks deliveries.
`timescale 1ns/1ps
module tb_if_prefetch;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_addr;

    if_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins        (ins),
        .ins_addr   (ins_addr)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ins;
    } exp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] addr;
    } req_t;

    exp_t        sb_q [$];
    req_t        rom_q [$];
    logic [31:0] lat = 32'd1;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_ins(input logic [31:0] a);
        sb_q.push_back(exp_t'{addr: a, ins: rom(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            sample();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d entries still pending, expected 0",
                     name, sb_q.size());
            sb_q.delete();
        end
        repeat (3) begin
            tick();
            sample();
        end
        chk({name, "_idle"}, 32'(ins_valid), 32'd0);
    endtask

    // ROM model: in-order responses, lat cycles after grant.
    req_t rom_r;
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rst && rom_q.size() > 0 && rom_q[0].due <= cyc) begin
                rom_r      = rom_q.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = rom(rom_r.addr);
            end
            @(negedge clk);
            if (!rst) begin
                rom_q.delete();
            end else if (mem_req && mem_gnt) begin
                rom_q.push_back(req_t'{due: cyc + lat, addr: mem_addr});
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted instruction.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst && !flush && ins_valid && ins_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ins: got addr %h, expected none",
                         ins_addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ins_addr", ins_addr, mon_e.addr);
                chk("ins", ins, mon_e.ins);
            end
        end
        if (rst && !ins_valid) begin
            chk("idle_ins", ins, 32'd0);
            chk("idle_ins_addr", ins_addr, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int g;
    int n;
    initial begin
        rst       = 1'b0;
        mem_gnt   = 1'b0;
        ins_ready = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        repeat (3) begin
            tick();
            sample();
        end
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_addr", ins_addr, 32'd0);

        // Stream with wrap: FFFF_FFF8, FFFF_FFFC, 0, 4, ...
        tick();
        lat       = 32'd1;
        mem_gnt   = 1'b1;
        ins_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_ins(RST_PC + 32'(4 * i));
        rst = 1'b1;
        sample();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, RST_PC);
        chk("c0_valid", 32'(ins_valid), 32'd0);
        tick();
        sample();
        chk("c1_valid", 32'(ins_valid), 32'd0);
        chk("c1_addr", mem_addr, RST_PC + 32'd4);
        for (int k = 2; k < 8; k++) begin
            tick();
            sample();
            chk("stream_valid", 32'(ins_valid), 32'd1);
            chk("stream_head", ins_addr, RST_PC + 32'(4 * (k - 2)));
            chk("stream_req", 32'(mem_req), 32'd1);
        end
        tick();
        mem_gnt = 1'b0;
        drain("stream_drain", 20);

        // Backpressure from address 0.
        tick();
        flush    = 1'b1;
        flush_pc = 32'h0;
        mem_gnt  = 1'b1;
        ins_ready = 1'b0;
        sample();
        chk("bp_flush_req", 32'(mem_req), 32'd0);
        tick();
        flush = 1'b0;
        sample();
        chk("bp_req", 32'(mem_req), 32'd1);
        chk("bp_addr", mem_addr, 32'h0);
        g = (mem_req && mem_gnt) ? 1 : 0;
        repeat (9) begin
            tick();
            sample();
            if (mem_req && mem_gnt) g++;
        end
        chk("bp_grants", 32'(g), 32'd4);
        chk("bp_req_stop", 32'(mem_req), 32'd0);
        chk("bp_head_valid", 32'(ins_valid), 32'd1);
        chk("bp_head_addr", ins_addr, 32'h0);
        for (int i = 0; i < 5; i++) expect_ins(32'(4 * i));
        n = 0;
        while (g < 5 && n < 20) begin
            tick();
            ins_ready = 1'b1;
            sample();
            if (mem_req && mem_gnt) g++;
            n++;
        end
        chk("bp_resume_grants", 32'(g), 32'd5);
        tick();
        mem_gnt = 1'b0;
        drain("bp_drain", 20);

        // Flush with three requests in flight, 4-cycle ROM.
        lat       = 32'd4;
        ins_ready = 1'b1;
        tick();
        mem_gnt = 1'b1;
        sample();
        chk("fl_first_addr", mem_addr, 32'h14);
        repeat (2) begin
            tick();
            sample();
        end
        tick();
        mem_gnt  = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h100;
        expect_ins(32'h100);
        expect_ins(32'h104);
        sample();
        chk("fl_req", 32'(mem_req), 32'd0);
        tick();
        flush   = 1'b0;
        mem_gnt = 1'b1;
        sample();
        chk("fl_redir_req", 32'(mem_req), 32'd1);
        chk("fl_redir_addr", mem_addr, 32'h100);
        tick();
        sample();
        chk("fl_next_addr", mem_addr, 32'h104);
        chk("fl_stale_valid", 32'(ins_valid), 32'd0);
        tick();
        mem_gnt = 1'b0;
        drain("fl_drain", 30);

        // Misaligned flush with coincident response and pop.
        lat       = 32'd1;
        ins_ready = 1'b1;
        tick();
        mem_gnt = 1'b1;
        expect_ins(32'h108);
        sample();
        chk("mis_addr0", mem_addr, 32'h108);
        tick();
        sample();
        tick();
        sample();
        chk("mis_head_valid", 32'(ins_valid), 32'd1);
        chk("mis_head_addr", ins_addr, 32'h108);
        tick();
        flush    = 1'b1;
        flush_pc = 32'h203;
        expect_ins(32'h200);
        expect_ins(32'h204);
        sample();
        chk("mis_flush_req", 32'(mem_req), 32'd0);
        chk("mis_flush_valid", 32'(ins_valid), 32'd1);
        tick();
        flush = 1'b0;
        sample();
        chk("mis_redir_req", 32'(mem_req), 32'd1);
        chk("mis_redir_addr", mem_addr, 32'h200);
        chk("mis_post_valid", 32'(ins_valid), 32'd0);
        tick();
        sample();
        chk("mis_next_addr", mem_addr, 32'h204);
        tick();
        mem_gnt = 1'b0;
        drain("mis_drain", 20);

        // Async reset with a full FIFO.
        tick();
        ins_ready = 1'b0;
        mem_gnt   = 1'b1;
        sample();
        repeat (8) begin
            tick();
            sample();
        end
        chk("ar_full_valid", 32'(ins_valid), 32'd1);
        chk("ar_full_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(ins_valid), 32'd0);
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_ins_addr", ins_addr, 32'd0);
        chk("ar_addr", mem_addr, RST_PC);
        sample();
        tick();
        sample();
        tick();
        ins_ready = 1'b1;
        expect_ins(RST_PC);
        expect_ins(RST_PC + 32'd4);
        rst = 1'b1;
        sample();
        chk("ar_restart_req", 32'(mem_req), 32'd1);
        chk("ar_restart_addr", mem_addr, RST_PC);
        tick();
        sample();
        chk("ar_next_addr", mem_addr, RST_PC + 32'd4);
        tick();
        mem_gnt = 1'b0;
        drain("ar_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
